data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
Word-organised data RAM for the memory stage of the 5-stage pipelined RISC-V-style processor. It performs a combinational read at byte address A and a synchronous write on the rising clock edge when WE is high. The memory-stage pipeline register captures RD in the same cycle the address is presented. Asynchronous reset clears the whole array.

Parameters:
WORD_SIZE, 32, data and address width in bits (codebase `WORD_SIZE`).
DEPTH, 64, number of WORD_SIZE-bit words stored; power of two, at least 2.

Ports:
clk  input  1  system clock; writes occur on its rising edge.
rst  input  1  asynchronous, active-high reset; clears every memory word.
WE  input  1  write enable (MemWriteM).
WD  input  WORD_SIZE  write data (WriteDataM).
A  input  WORD_SIZE  byte address (ALUResultM).
RD  output  WORD_SIZE  read data at A (ReadDataM), combinational.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst); polarity and synchronicity are fixed.
- Storage: DEPTH words of WORD_SIZE bits.
- Word index = A[log2(DEPTH)+1 : 2]. A[1:0] is ignored; there is no byte or halfword access and no misalignment fault.
- An address is in range when A[WORD_SIZE-1 : log2(DEPTH)+2] == 0, that is A < 4*DEPTH.
- Read:
  - Purely combinational; zero-cycle latency.
  - RD = mem[index] when in range, else 32'h0.
  - RD responds to changes on A, or to array contents, within the same cycle.
- Write:
  - On posedge clk with rst low and WE high and A in range: mem[index] <= WD.
  - With WE low, or A out of range, the array is unchanged (out-of-range writes are silently dropped, no aliasing).
- Read-during-write to the same address:
  - Before the edge, RD shows the old contents.
  - After the edge, RD shows WD (write-first visible next cycle via the combinational path).
  - There is no bypass of WD to RD within the write cycle.
- Reset:
  - While rst is high, all DEPTH words are 0 and RD = 0, regardless of clk, WE or A.
  - Writes are blocked while rst is asserted.
  - Reset asserted mid-operation takes effect immediately and is not aligned to clk.
  - After rst is deasserted, the first write happens on the next posedge with WE high.
- X/uninitialised contents are never visible after the first reset.
- Simulation-only $display or debug output is not part of the block.

Test Plan:
1. Reset: assert rst, then read A=0x0, 0x4, 0xFC -> RD=0x00000000 for every address. Assert WE=1 with WD=0xFFFFFFFF during reset and clock -> contents remain 0.
2. Write/readback: WE=1, A=0x8, WD=0xDEADBEEF, one posedge. Then WE=0 -> RD=0xDEADBEEF at A=0x8, and RD=0 at A=0x4 and A=0xC.
3. Alignment: after scenario 2, A=0x9, 0xA and 0xB -> RD=0xDEADBEEF. Write WD=0x12345678 at A=0xB -> readback at A=0x8 is 0x12345678.
4. Bounds (DEPTH=64): write 0xA5A5A5A5 at A=0xFC -> reads back. Write 0x5A5A5A5A at A=0x100 -> RD at 0x100 is 0 and RD at 0x0 is still 0.
5. Read-during-write: mem[0x10]=0x11111111, then WE=1, A=0x10, WD=0x22222222. RD=0x11111111 before the edge and 0x22222222 after the edge.
6. Async reset mid-run: fill 0x0–0x1C with nonzero values, then pulse rst between clock edges -> RD drops to 0 immediately. All eight words read 0 after release.

Source files
------------

// File: rtl/data_memory.sv
// Word-organised data RAM for the memory stage: combinational read, synchronous write,
// asynchronous active-high reset that clears every word.
module data_memory #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned DEPTH     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 WE,
   input  logic [WORD_SIZE-1:0] WD,
   input  logic [WORD_SIZE-1:0] A,
   output logic [WORD_SIZE-1:0] RD
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [IdxW-1:0]      wordIdx;
   logic                 inRange;

   // A[1:0] is ignored; any set bit above the index field means out of range (no aliasing).
   assign wordIdx = A[IdxW+1:2];
   assign inRange = ((A >> (IdxW + 2)) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (WE && inRange) begin
         mem[wordIdx] <= WD;
      end
   end

   always_comb begin
      RD = '0;
      if (!rst && inRange) begin
         RD = mem[wordIdx];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read data, a monitor checks RD
// at each falling edge against a byte-address reference model.
module tb_data_memory;

   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned DEPTH     = 64;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 WE  = 1'b0;
   logic [WORD_SIZE-1:0] WD  = '0;
   logic [WORD_SIZE-1:0] A   = '0;
   logic [WORD_SIZE-1:0] RD;

   data_memory #(
      .WORD_SIZE(WORD_SIZE),
      .DEPTH    (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .WE (WE),
      .WD (WD),
      .A  (A),
      .RD (RD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WORD_SIZE-1:0] exp;
      string                name;
   } exp_t;

   exp_t                 sbq [$];
   int                   checks = 0;
   int                   passed = 0;
   logic [WORD_SIZE-1:0] model [DEPTH];

   function automatic logic [WORD_SIZE-1:0] refRead(input logic [WORD_SIZE-1:0] a);
      if (a < 32'(4 * DEPTH)) return model[a / 4];
      return '0;
   endfunction

   // One cycle of stimulus: drive just after the rising edge, expect RD at the falling edge,
   // then let the model absorb the write that lands on the following rising edge.
   task automatic step(input logic r, input logic we, input logic [WORD_SIZE-1:0] wd,
                       input logic [WORD_SIZE-1:0] a, input bit useModel,
                       input logic [WORD_SIZE-1:0] cexp, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      WE  = we;
      WD  = wd;
      A   = a;
      if (r) begin
         for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
         e.exp = '0;
      end else begin
         e.exp = useModel ? refRead(a) : cexp;
      end
      e.name = name;
      sbq.push_back(e);
      if (!r && we && a < 32'(4 * DEPTH)) model[a / 4] = wd;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (RD === e.exp) passed++;
            else $display("FAIL %s: A=%h RD=%h expected %h", e.name, A, RD, e.exp);
         end
      end
   end

   initial begin : stimulus
      logic [WORD_SIZE-1:0] ra;
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

      // Reset holds everything at zero and blocks writes.
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,  1'b0, 32'h0, "rst_rd_0");
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h4,  1'b0, 32'h0, "rst_rd_4");
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFC, 1'b0, 32'h0, "rst_rd_fc");
      step(1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 32'h0, "post_rst_0");
      step(1'b0, 1'b0, 32'h0, 32'hFC, 1'b0, 32'h0, "post_rst_fc");

      // Write / readback and neighbours.
      step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h8, 1'b0, 32'h0, "wr8_before");
      step(1'b0, 1'b0, 32'h0, 32'h8, 1'b0, 32'hDEAD_BEEF, "rd8");
      step(1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 32'h0, "rd4");
      step(1'b0, 1'b0, 32'h0, 32'hC, 1'b0, 32'h0, "rdC");

      // Low address bits are ignored.
      step(1'b0, 1'b0, 32'h0, 32'h9, 1'b0, 32'hDEAD_BEEF, "rd9");
      step(1'b0, 1'b0, 32'h0, 32'hA, 1'b0, 32'hDEAD_BEEF, "rdA");
      step(1'b0, 1'b0, 32'h0, 32'hB, 1'b0, 32'hDEAD_BEEF, "rdB");
      step(1'b0, 1'b1, 32'h1234_5678, 32'hB, 1'b0, 32'hDEAD_BEEF, "wrB_before");
      step(1'b0, 1'b0, 32'h0, 32'h8, 1'b0, 32'h1234_5678, "rd8_after_wrB");

      // Bounds: last word is writable, first out-of-range address is dropped.
      step(1'b0, 1'b1, 32'hA5A5_A5A5, 32'hFC, 1'b0, 32'h0, "wrFC_before");
      step(1'b0, 1'b0, 32'h0, 32'hFC, 1'b0, 32'hA5A5_A5A5, "rdFC");
      step(1'b0, 1'b1, 32'h5A5A_5A5A, 32'h100, 1'b0, 32'h0, "wr100_before");
      step(1'b0, 1'b0, 32'h0, 32'h100, 1'b0, 32'h0, "rd100");
      step(1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 32'h0, "rd0_no_alias");

      // Read-during-write: old data before the edge, new data after.
      step(1'b0, 1'b1, 32'h1111_1111, 32'h10, 1'b0, 32'h0, "wr10_first");
      step(1'b0, 1'b1, 32'h2222_2222, 32'h10, 1'b0, 32'h1111_1111, "rdw_before");
      step(1'b0, 1'b0, 32'h0, 32'h10, 1'b0, 32'h2222_2222, "rdw_after");

      // Fill 0x0-0x1C, then an asynchronous reset pulse between edges.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 32'hC0DE_0001 + 32'(i), 32'(4 * i), 1'b1, 32'h0, "fill");
      end
      step(1'b0, 1'b0, 32'h0, 32'h1C, 1'b0, 32'hC0DE_0008, "rd1C_filled");
      step(1'b1, 1'b0, 32'h0, 32'h1C, 1'b0, 32'h0, "async_rst");
      @(negedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 32'h0, 32'(4 * i), 1'b0, 32'h0, "after_rst");
      end

      // Randomised traffic, including out-of-range addresses and occasional resets.
      for (int n = 0; n < 400; n++) begin
         ra = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 'h13F));
         step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 32'($urandom), ra,
              1'b1, 32'h0, "rand");
      end
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "final");

      repeat (3) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
